// File: rtl/ifetch_task_switch.sv
// ifetch_task_switch: tracks the running (channel, thread), buffers pending task
// requests in a FIFO and drives the per-thread fetch PC into the fetch pipeline.
module ifetch_task_switch #(
    parameter int CHANNEL_BITS = 3,
    parameter int THREAD_BITS  = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int QUEUE_BITS   = 2,
    parameter int IDLE_THREAD  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    next_task_ready,
    input  logic [CHANNEL_BITS-1:0] next_task_channel,
    input  logic [THREAD_BITS-1:0]  next_task_thread,
    output logic                    next_task_ack,
    input  logic                    task_yield,
    output logic [CHANNEL_BITS-1:0] current_channel,
    output logic [THREAD_BITS-1:0]  current_thread,
    output logic                    fetch_valid,
    input  logic                    fetch_stall,
    output logic [ADDR_WIDTH-1:0]   fetch_pc,
    input  logic                    pc_load,
    input  logic [ADDR_WIDTH-1:0]   pc_load_value,
    output logic [QUEUE_BITS:0]     queue_count,
    output logic                    bad_request
);
    localparam int DEPTH = 2 ** QUEUE_BITS;
    localparam int NTHR  = 2 ** THREAD_BITS;
    localparam logic [THREAD_BITS-1:0] IDLE_T = THREAD_BITS'(IDLE_THREAD);

    typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CHANNEL_BITS-1:0] chan_q, chan_d;
    logic [THREAD_BITS-1:0]  thr_q, thr_d;
    logic                    ack_q, ack_d;
    logic                    bad_q, bad_d;
    logic [QUEUE_BITS-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [QUEUE_BITS:0]     cnt_q, cnt_d;
    logic [CHANNEL_BITS-1:0] q_ch_q [DEPTH], q_ch_d [DEPTH];
    logic [THREAD_BITS-1:0]  q_th_q [DEPTH], q_th_d [DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_q [NTHR], pc_d [NTHR];

    logic req, bad, good, full, empty, enq, deq;

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        thr_d   = thr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        q_ch_d  = q_ch_q;
        q_th_d  = q_th_q;
        pc_d    = pc_q;
        enq     = 1'b0;
        deq     = 1'b0;
        // A request still high while its ack is visible is the old one, not a new one.
        req     = next_task_ready && !ack_q;
        bad     = req && (next_task_thread == IDLE_T);
        good    = req && !bad;
        full    = cnt_q == (QUEUE_BITS+1)'(DEPTH);
        empty   = cnt_q == '0;
        ack_d   = bad;
        bad_d   = bad;
        case (state_q)
            IDLE: begin
                if (good) begin
                    chan_d  = next_task_channel;
                    thr_d   = next_task_thread;
                    ack_d   = 1'b1;
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                state_d = RUN;
                enq     = good && !full;
            end
            RUN: begin
                if (pc_load)
                    pc_d[thr_q] = pc_load_value;
                else if (!task_yield && !fetch_stall)
                    pc_d[thr_q] = pc_q[thr_q] + ADDR_WIDTH'(1);
                if (!task_yield) begin
                    enq = good && !full;
                end else if (!empty) begin
                    // The dequeue frees a slot, so a concurrent request always fits.
                    deq     = 1'b1;
                    enq     = good;
                    chan_d  = q_ch_q[rd_q];
                    thr_d   = q_th_q[rd_q];
                    state_d = SWITCH;
                end else if (good) begin
                    chan_d  = next_task_channel;
                    thr_d   = next_task_thread;
                    ack_d   = 1'b1;
                    state_d = SWITCH;
                end else begin
                    chan_d  = '0;
                    thr_d   = IDLE_T;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enq) begin
            q_ch_d[wr_q] = next_task_channel;
            q_th_d[wr_q] = next_task_thread;
            wr_d         = wr_q + QUEUE_BITS'(1);
            ack_d        = 1'b1;
        end
        if (deq)
            rd_d = rd_q + QUEUE_BITS'(1);
        cnt_d = cnt_q + (QUEUE_BITS+1)'(enq) - (QUEUE_BITS+1)'(deq);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            thr_q   <= IDLE_T;
            ack_q   <= 1'b0;
            bad_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            q_ch_q  <= '{default: '0};
            q_th_q  <= '{default: '0};
            pc_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            thr_q   <= thr_d;
            ack_q   <= ack_d;
            bad_q   <= bad_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            q_ch_q  <= q_ch_d;
            q_th_q  <= q_th_d;
            pc_q    <= pc_d;
        end
    end

    assign next_task_ack   = ack_q;
    assign bad_request     = bad_q;
    assign current_channel = chan_q;
    assign current_thread  = thr_q;
    assign fetch_valid     = state_q == RUN;
    assign fetch_pc        = pc_q[thr_q];
    assign queue_count     = cnt_q;
endmodule

// File: tb/tb_ifetch_task_switch.sv
// tb_ifetch_task_switch: random requests, yields, stalls and redirects checked
// cycle by cycle against a queue-based behavioural model of the task switcher.
module tb_ifetch_task_switch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rdy = 1'b0;
    logic [2:0]  ch = '0;
    logic [1:0]  th = '0;
    logic        ack;
    logic        yield_i = 1'b0;
    logic [2:0]  cur_ch;
    logic [1:0]  cur_th;
    logic        fvalid;
    logic        stall = 1'b0;
    logic [15:0] fpc;
    logic        pcl = 1'b0;
    logic [15:0] pcl_val = '0;
    logic [2:0]  qcnt;
    logic        badreq;

    ifetch_task_switch dut (
        .clk(clk), .reset_n(reset_n),
        .next_task_ready(rdy), .next_task_channel(ch), .next_task_thread(th),
        .next_task_ack(ack), .task_yield(yield_i),
        .current_channel(cur_ch), .current_thread(cur_th),
        .fetch_valid(fvalid), .fetch_stall(stall), .fetch_pc(fpc),
        .pc_load(pcl), .pc_load_value(pcl_val),
        .queue_count(qcnt), .bad_request(badreq)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int t; } task_t;

    int    n_total = 0;
    int    n_bad   = 0;
    task_t m_q[$];
    int    m_pc[4];
    bit    m_busy, m_bubble, m_ack, m_bad;
    int    m_ch, m_th;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        foreach (m_pc[i]) m_pc[i] = 0;
        m_busy = 0; m_bubble = 0; m_ack = 0; m_bad = 0;
        m_ch = 0; m_th = 3;
    endtask

    task automatic model_step();
        bit req, badr, good;
        task_t r;
        req  = rdy && !m_ack;
        badr = req && th == 2'd3;
        good = req && !badr;
        r.c = int'(ch); r.t = int'(th);
        m_ack = badr;
        m_bad = badr;
        if (!m_busy) begin
            if (good) begin
                m_ch = r.c; m_th = r.t; m_busy = 1; m_bubble = 1; m_ack = 1;
            end
        end else if (m_bubble) begin
            m_bubble = 0;
            if (good && m_q.size() < 4) begin m_q.push_back(r); m_ack = 1; end
        end else begin
            if (pcl) m_pc[m_th] = int'(pcl_val);
            else if (!yield_i && !stall) m_pc[m_th] = (m_pc[m_th] + 1) % 65536;
            if (!yield_i) begin
                if (good && m_q.size() < 4) begin m_q.push_back(r); m_ack = 1; end
            end else if (m_q.size() > 0) begin
                task_t h = m_q.pop_front();
                if (good) begin m_q.push_back(r); m_ack = 1; end
                m_ch = h.c; m_th = h.t; m_bubble = 1;
            end else if (good) begin
                m_ch = r.c; m_th = r.t; m_bubble = 1; m_ack = 1;
            end else begin
                m_busy = 0; m_ch = 0; m_th = 3;
            end
        end
    endtask

    task automatic check_all();
        check("ack", 32'(ack), 32'(m_ack));
        check("bad_request", 32'(badreq), 32'(m_bad));
        check("channel", 32'(cur_ch), 32'(m_ch));
        check("thread", 32'(cur_th), 32'(m_th));
        check("fetch_valid", 32'(fvalid), 32'(m_busy && !m_bubble));
        check("fetch_pc", 32'(fpc), 32'(m_pc[m_th]));
        check("queue_count", 32'(qcnt), 32'(m_q.size()));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic randomize_inputs(input int yield_div);
        if (rdy && m_ack) rdy = ($urandom % 4 == 0);
        else if (!rdy && $urandom % 3 == 0) begin
            rdy = 1'b1;
            ch  = 3'($urandom);
            th  = 2'($urandom);
        end
        yield_i = ($urandom % yield_div == 0);
        stall   = ($urandom % 4 == 0);
        pcl     = ($urandom % 16 == 0);
        case ($urandom % 4)
            0: pcl_val = 16'hFFFF;
            1: pcl_val = 16'hFFFE;
            2: pcl_val = 16'h0010;
            default: pcl_val = 16'($urandom);
        endcase
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_qcount", 32'(qcnt), 32'd0);
        check("reset_thread", 32'(cur_th), 32'd3);
        reset_n = 1'b1;
        repeat (3) step();
        rdy = 1'b1; ch = 3'd7; th = 2'd0;
        step();
        rdy = 1'b0;
        step();
        for (int i = 0; i < 4000; i++) begin
            randomize_inputs(i < 2000 ? 16 : 5);
            step();
        end
        rdy = 1'b0; yield_i = 1'b0; pcl = 1'b0;
        for (int i = 0; i < 200 && m_q.size() < 2; i++) begin
            if (!rdy && !m_ack) begin rdy = 1'b1; ch = 3'($urandom); th = 2'($urandom % 3); end
            else if (m_ack) rdy = 1'b0;
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_reset_qcount", 32'(qcnt), 32'd0);
        rdy = 1'b0; yield_i = 1'b0; stall = 1'b0; pcl = 1'b0;
        #10;
        reset_n = 1'b1;
        repeat (3) step();
        rdy = 1'b1; ch = 3'd5; th = 2'd2;
        step();
        rdy = 1'b0;
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
